// File: rtl/cxd2545_pkg.sv
// Shared types and constants for the CXD2545 serial command link (CLK/DATA/XLAT/SENS).
package cxd2545_pkg;

  localparam int unsigned CXD_CLK_DIV     = 4;
  localparam int unsigned CXD_MAX_BITS    = 24;
  localparam int unsigned CXD_XLAT_LEN    = 4;
  localparam int unsigned CXD_SENS_DELAY  = 8;
  localparam int unsigned CXD_LEN_W       = 5;
  localparam int unsigned CXD_DEFAULT_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_LATCH,
    ST_SETTLE,
    ST_CAPTURE
  } cxd_state_e;

  // Registered pin bundle driven toward the DSP
  typedef struct packed {
    logic clk;
    logic data;
    logic xlat;
  } cxd_pins_t;

  localparam cxd_pins_t CXD_PINS_IDLE = '{clk: 1'b1, data: 1'b0, xlat: 1'b1};

  // SENS select nibble: the last four bits shifted out of a command word
  localparam logic [3:0] CXD_SEL_FOCUS     = 4'h0;
  localparam logic [3:0] CXD_SEL_TRACKING  = 4'h1;
  localparam logic [3:0] CXD_SEL_TRK_MODE  = 4'h2;
  localparam logic [3:0] CXD_SEL_SELECT    = 4'h3;
  localparam logic [3:0] CXD_SEL_AUTO_SEQ  = 4'h4;
  localparam logic [3:0] CXD_SEL_BLIND_BRK = 4'h5;
  localparam logic [3:0] CXD_SEL_KICK      = 4'h6;
  localparam logic [3:0] CXD_SEL_TRK_CNT   = 4'h7;
  localparam logic [3:0] CXD_SEL_MODE      = 4'h8;
  localparam logic [3:0] CXD_SEL_CLV       = 4'hE;

  // Effective frame length: zero means a default byte, oversize clamps to the word width
  function automatic int unsigned cxd_eff_len(input logic [CXD_LEN_W-1:0] len,
                                              input int unsigned max_bits);
    int unsigned n;
    n = (len == '0) ? CXD_DEFAULT_LEN : 32'(len);
    if (n > max_bits) n = max_bits;
    return n;
  endfunction

endpackage

// File: rtl/cxd2545_bit_timer.sv
// Loadable down-counter; o_tc_c is high while the count sits at zero.
module cxd2545_bit_timer
  import cxd2545_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Loading N-1 on entry makes the owning state last exactly N cycles
  assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/cxd2545_cmd_tx.sv
// CXD2545 serial command master: shifts a word out LSB first, pulses XLAT, then samples SENS.
module cxd2545_cmd_tx
  import cxd2545_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CXD_CLK_DIV,
  parameter int unsigned MAX_BITS   = CXD_MAX_BITS,
  parameter int unsigned XLAT_LEN   = CXD_XLAT_LEN,
  parameter int unsigned SENS_DELAY = CXD_SENS_DELAY
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [MAX_BITS-1:0]  cmd_data,
  input  logic [CXD_LEN_W-1:0] cmd_len,
  output logic                 busy,
  output logic                 sens_valid,
  output logic                 sens_value,
  output logic                 cx_clk,
  output logic                 cx_data,
  output logic                 cx_xlat,
  input  logic                 cx_sens
);

  localparam int unsigned TMR_MAX_A = (CLK_DIV > XLAT_LEN) ? CLK_DIV : XLAT_LEN;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > SENS_DELAY) ? TMR_MAX_A : SENS_DELAY;
  localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned CNT_W     = $clog2(MAX_BITS + 1);

  cxd_state_e           r_state;
  cxd_state_e           w_next;
  logic [MAX_BITS-1:0]  r_shift;
  logic [CNT_W-1:0]     r_bits;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_sens_valid;
  logic                 r_sens_value;
  logic                 r_sens_meta;
  logic                 r_sens_sync;
  cxd_pins_t            r_pins;
  cxd_pins_t            w_pins;
  logic                 w_accept;
  logic                 w_tmr_load;
  logic [TMR_W-1:0]     w_tmr_val;
  logic                 w_tc;
  logic                 w_last_bit;
  logic                 w_shift_en;

  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_last_bit = (r_bits <= CNT_W'(1));
  assign w_shift_en = (r_state == ST_HIGH) && w_tc;

  cxd2545_bit_timer #(
    .W (TMR_W)
  ) u_timer (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc_c     (w_tc)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, interval reload and the pin levels belonging to the current state
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_pins     = CXD_PINS_IDLE;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next     = ST_LOW;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(CLK_DIV - 1);
        end
      end
      ST_LOW: begin
        w_pins.clk  = 1'b0;
        w_pins.data = r_shift[0];
        if (w_tc) begin
          w_next     = ST_HIGH;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(CLK_DIV - 1);
        end
      end
      ST_HIGH: begin
        w_pins.data = r_shift[0];
        if (w_tc) begin
          w_tmr_load = 1'b1;
          if (w_last_bit) begin
            w_next    = ST_LATCH;
            w_tmr_val = TMR_W'(XLAT_LEN - 1);
          end else begin
            w_next    = ST_LOW;
            w_tmr_val = TMR_W'(CLK_DIV - 1);
          end
        end
      end
      ST_LATCH: begin
        w_pins.xlat = 1'b0;
        if (w_tc) begin
          w_next     = ST_SETTLE;
          w_tmr_load = 1'b1;
          w_tmr_val  = TMR_W'(SENS_DELAY - 1);
        end
      end
      ST_SETTLE: begin
        if (w_tc) begin
          w_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Command word and remaining-bit count
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_bits  <= '0;
    end else if (w_accept) begin
      r_shift <= cmd_data;
      r_bits  <= CNT_W'(cxd_eff_len(cmd_len, MAX_BITS));
    end else if (w_shift_en) begin
      r_shift <= r_shift >> 1;
      r_bits  <= r_bits - CNT_W'(1);
    end
  end

  // SENS is asynchronous to sclk; the synchronizer runs regardless of state
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sens_meta <= 1'b0;
      r_sens_sync <= 1'b0;
    end else begin
      r_sens_meta <= cx_sens;
      r_sens_sync <= r_sens_meta;
    end
  end

  // Output registers trail the state by one cycle so every pin is a clean flop output
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pins       <= CXD_PINS_IDLE;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_sens_valid <= 1'b0;
      r_sens_value <= 1'b0;
    end else begin
      r_pins       <= w_pins;
      r_cmd_ready  <= (r_state == ST_IDLE) && !w_accept;
      r_busy       <= !((r_state == ST_IDLE) && !w_accept);
      r_sens_valid <= (r_state == ST_CAPTURE);
      if (r_state == ST_CAPTURE) begin
        r_sens_value <= r_sens_sync;
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign sens_valid = r_sens_valid;
  assign sens_value = r_sens_value;
  assign cx_clk     = r_pins.clk;
  assign cx_data    = r_pins.data;
  assign cx_xlat    = r_pins.xlat;

endmodule

// File: tb/tb_cxd2545_cmd_tx.sv
// Bench for cxd2545_cmd_tx: two instances (default timing, fast timing) against a frame-level model.
module tb_cxd2545_cmd_tx;
  import cxd2545_pkg::*;

  localparam int unsigned MB  = 24;
  localparam int unsigned C0  = 4;
  localparam int unsigned SD0 = 8;
  localparam int unsigned C1  = 1;
  localparam int unsigned SD1 = 2;
  localparam int unsigned XL  = 4;

  logic sclk = 1'b0;
  logic rst_n;
  always #5 sclk = ~sclk;

  logic          in_valid [2];
  logic [MB-1:0] in_data  [2];
  logic [4:0]    in_len   [2];
  logic          in_sens  [2];
  logic          o_ready  [2];
  logic          o_busy   [2];
  logic          o_sv     [2];
  logic          o_sval   [2];
  logic          o_clk    [2];
  logic          o_data   [2];
  logic          o_xlat   [2];

  cxd2545_cmd_tx #(
    .CLK_DIV (C0), .MAX_BITS (MB), .XLAT_LEN (XL), .SENS_DELAY (SD0)
  ) u_dut_a (
    .sclk (sclk), .rst_n (rst_n), .cmd_valid (in_valid[0]), .cmd_ready (o_ready[0]),
    .cmd_data (in_data[0]), .cmd_len (in_len[0]), .busy (o_busy[0]),
    .sens_valid (o_sv[0]), .sens_value (o_sval[0]), .cx_clk (o_clk[0]),
    .cx_data (o_data[0]), .cx_xlat (o_xlat[0]), .cx_sens (in_sens[0])
  );

  cxd2545_cmd_tx #(
    .CLK_DIV (C1), .MAX_BITS (MB), .XLAT_LEN (XL), .SENS_DELAY (SD1)
  ) u_dut_b (
    .sclk (sclk), .rst_n (rst_n), .cmd_valid (in_valid[1]), .cmd_ready (o_ready[1]),
    .cmd_data (in_data[1]), .cmd_len (in_len[1]), .busy (o_busy[1]),
    .sens_valid (o_sv[1]), .sens_value (o_sval[1]), .cx_clk (o_clk[1]),
    .cx_data (o_data[1]), .cx_xlat (o_xlat[1]), .cx_sens (in_sens[1])
  );

  int n_checks;
  int n_pass;
  int cyc;
  bit chk_en;

  // Frame-level model state
  bit            m_busy [2];
  int            m_t    [2];
  logic [MB-1:0] m_word [2];
  int            m_n    [2];
  logic          m_sval [2];
  logic          hist   [2][4];

  // Loopback receiver state
  logic [MB-1:0] rx_word   [2];
  int            rx_cnt    [2];
  logic [MB-1:0] last_word [2];
  int            last_cnt  [2];
  logic [3:0]    last_nib  [2];
  logic          prev_clk  [2];
  logic          prev_xlat [2];

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, u, cyc, act, exp);
  endtask

  function automatic int cdiv(input int u);
    return (u == 0) ? C0 : C1;
  endfunction

  function automatic int sdel(input int u);
    return (u == 0) ? SD0 : SD1;
  endfunction

  function automatic int frame_end(input int u, input int n);
    return 2 * cdiv(u) * n + XL + sdel(u) + 1;
  endfunction

  // Expected {ready, busy, sens_valid, sens_value, cx_clk, cx_data, cx_xlat} d cycles after accept
  function automatic logic [6:0] expect_out(input int u, input bit busy_f, input int d,
                                            input logic [MB-1:0] w, input int n, input logic sval);
    logic rdy, sv, ck, dt, xl;
    int c, sh;
    rdy = 1'b0; sv = 1'b0; ck = 1'b1; dt = 1'b0; xl = 1'b1;
    c  = cdiv(u);
    sh = 2 * c * n;
    if (!busy_f) begin
      rdy = 1'b1;
    end else if (d >= 1 && d <= sh) begin
      ck = ((d - 1) % (2 * c)) >= c;
      dt = w[(d - 1) / (2 * c)];
    end else if (d > sh && d <= sh + XL) begin
      xl = 1'b0;
    end else if (d == sh + XL + sdel(u) + 1) begin
      sv = 1'b1;
    end
    return {rdy, ~rdy, sv, sval, ck, dt, xl};
  endfunction

  // Model advance: accept, SENS history, capture and frame end
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_busy[u] = 1'b0;
        m_sval[u] = 1'b0;
      end
    end else begin
      cyc++;
      for (int u = 0; u < 2; u++) begin
        hist[u][cyc % 4] = in_sens[u];
        if (m_busy[u]) begin
          if (cyc - m_t[u] == frame_end(u, m_n[u])) m_sval[u] = hist[u][(cyc - 2) % 4];
          if (cyc - m_t[u] == frame_end(u, m_n[u]) + 1) m_busy[u] = 1'b0;
        end else if (in_valid[u] === 1'b1) begin
          m_busy[u] = 1'b1;
          m_t[u]    = cyc;
          m_n[u]    = (in_len[u] == 0) ? 8 : ((int'(in_len[u]) > MB) ? MB : int'(in_len[u]));
          for (int i = 0; i < MB; i++) m_word[u][i] = (i < m_n[u]) ? in_data[u][i] : 1'b0;
        end
      end
    end
  end

  // Per-cycle compare plus loopback receiver
  always @(negedge sclk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        logic [6:0] exp_v, act_v;
        exp_v = expect_out(u, m_busy[u], cyc - m_t[u], m_word[u], m_n[u], m_sval[u]);
        act_v = {o_ready[u], o_busy[u], o_sv[u], o_sval[u], o_clk[u], o_data[u], o_xlat[u]};
        check("cycle_outputs", u, 32'(act_v), 32'(exp_v));
        if (!rst_n) begin
          rx_cnt[u] = 0;
        end else begin
          if (o_clk[u] && !prev_clk[u] && o_xlat[u]) begin
            if (rx_cnt[u] < MB) rx_word[u][rx_cnt[u]] = o_data[u];
            rx_cnt[u]++;
          end
          if (!o_xlat[u] && prev_xlat[u]) begin
            for (int i = rx_cnt[u]; i < MB; i++) rx_word[u][i] = 1'b0;
            last_word[u] = rx_word[u];
            last_cnt[u]  = rx_cnt[u];
            if (rx_cnt[u] >= 4 && rx_cnt[u] <= MB) last_nib[u] = rx_word[u][rx_cnt[u]-1 -: 4];
            check("rx_len", u, 32'(rx_cnt[u]), 32'(m_n[u]));
            check("rx_word", u, 32'(rx_word[u]), 32'(m_word[u]));
            rx_cnt[u] = 0;
          end
        end
        prev_clk[u]  = o_clk[u];
        prev_xlat[u] = o_xlat[u];
      end
    end
  end

  task automatic at_cycle(input int tgt);
    int g;
    g = 0;
    while (cyc < tgt && g < 5000) begin
      @(posedge sclk); #1; g++;
    end
    if (cyc != tgt) check("at_cycle", 0, 32'(cyc), 32'(tgt));
  endtask

  task automatic wait_idle(input int u, input bit rnd);
    int g;
    g = 0;
    while (m_busy[u] && g < 4000) begin
      @(posedge sclk); #1; g++;
      if (m_busy[u] && rnd) begin
        in_sens[u]  = 1'($urandom_range(0, 1));
        in_valid[u] = ($urandom_range(0, 15) == 0);
        in_data[u]  = MB'($urandom);
        in_len[u]   = 5'($urandom);
      end
    end
    in_valid[u] = 1'b0;
    if (m_busy[u]) check("idle_timeout", u, 32'd1, 32'd0);
  endtask

  task automatic send(input int u, input logic [MB-1:0] w, input logic [4:0] l,
                      input bit hold, output int t);
    wait_idle(u, 1'b0);
    in_valid[u] = 1'b1;
    in_data[u]  = w;
    in_len[u]   = l;
    @(posedge sclk); #1;
    t = cyc;
    if (!hold) in_valid[u] = 1'b0;
  endtask

  initial begin
    int t;
    logic [7:0] tp;
    n_checks = 0; n_pass = 0; cyc = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_data[u] = '0; in_len[u] = '0; in_sens[u] = 1'b0;
      m_busy[u] = 1'b0; m_t[u] = 0; m_word[u] = '0; m_n[u] = 8; m_sval[u] = 1'b0;
      rx_word[u] = '0; rx_cnt[u] = 0; last_word[u] = '0; last_cnt[u] = 0; last_nib[u] = '0;
      prev_clk[u] = 1'b1; prev_xlat[u] = 1'b1;
      for (int i = 0; i < 4; i++) hist[u][i] = 1'b0;
    end
    repeat (3) @(posedge sclk);
    #1;
    chk_en = 1'b1;
    check("reset_state", 0, 32'({o_ready[0], o_busy[0], o_sv[0], o_sval[0], o_clk[0], o_data[0], o_xlat[0]}), 32'h45);
    check("reset_state", 1, 32'({o_ready[1], o_busy[1], o_sv[1], o_sval[1], o_clk[1], o_data[1], o_xlat[1]}), 32'h45);
    @(posedge sclk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge sclk); #1; end

    // 0x20, 8 bits, SENS high: bit timing, XLAT window, capture and ready return
    in_sens[0] = 1'b1;
    tp = 8'h20;
    send(0, 24'h000020, 5'd8, 1'b0, t);
    for (int k = 0; k < 8; k++) begin
      at_cycle(t + 1 + (2 * k + 1) * 4);
      check("t1_rise_bit", 0, 32'({o_clk[0], o_data[0]}), 32'({1'b1, tp[k]}));
    end
    at_cycle(t + 64); check("t1_xlat_pre", 0, 32'(o_xlat[0]), 32'd1);
    at_cycle(t + 65); check("t1_xlat_fall", 0, 32'(o_xlat[0]), 32'd0);
    at_cycle(t + 68); check("t1_xlat_last", 0, 32'(o_xlat[0]), 32'd0);
    at_cycle(t + 69); check("t1_xlat_rise", 0, 32'(o_xlat[0]), 32'd1);
    at_cycle(t + 76); check("t1_sv_pre", 0, 32'(o_sv[0]), 32'd0);
    at_cycle(t + 77); check("t1_sv", 0, 32'({o_sv[0], o_sval[0], o_ready[0]}), 32'b110);
    at_cycle(t + 78); check("t1_ready", 0, 32'({o_sv[0], o_ready[0]}), 32'b01);

    // Length rule: zero -> 8, oversize -> 24
    send(0, 24'hFFFFFF, 5'd0, 1'b0, t);
    wait_idle(0, 1'b0);
    check("t2_len0_pulses", 0, 32'(last_cnt[0]), 32'd8);
    check("t2_len0_word", 0, 32'(last_word[0]), 32'h0000FF);
    send(0, 24'hFFFFFF, 5'd31, 1'b0, t);
    wait_idle(0, 1'b0);
    check("t2_len31_pulses", 0, 32'(last_cnt[0]), 32'd24);
    check("t2_len31_word", 0, 32'(last_word[0]), 32'hFFFFFF);

    // Back-to-back with cmd_valid held; data change during frame 1 is ignored
    send(0, 24'h000005, 5'd8, 1'b1, t);
    in_data[0] = 24'h00000A;
    at_cycle(t + 70); check("t3_first_word", 0, 32'(last_word[0]), 32'h05);
    at_cycle(t + 78); check("t3_ready_back", 0, 32'({o_ready[0], o_clk[0], o_xlat[0]}), 32'b111);
    at_cycle(t + 79);
    in_valid[0] = 1'b0;
    check("t3_second_accept", 0, 32'({o_ready[0], o_clk[0], o_xlat[0]}), 32'b011);
    at_cycle(t + 80); check("t3_second_fall", 0, 32'(o_clk[0]), 32'd0);
    wait_idle(0, 1'b0);
    check("t3_second_word", 0, 32'(last_word[0]), 32'h0A);

    // Mid-frame request with a different word is dropped
    send(0, 24'h00003C, 5'd8, 1'b0, t);
    at_cycle(t + 10);
    in_valid[0] = 1'b1; in_data[0] = 24'h0000C3;
    at_cycle(t + 11);
    in_valid[0] = 1'b0;
    check("t4_ready_low", 0, 32'(o_ready[0]), 32'd0);
    wait_idle(0, 1'b0);
    check("t4_word", 0, 32'(last_word[0]), 32'h3C);

    // Reset during bit 3 drops straight to idle levels
    send(0, 24'h0000A5, 5'd8, 1'b0, t);
    at_cycle(t + 26);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_reset_abort", 0, 32'({o_ready[0], o_busy[0], o_sv[0], o_clk[0], o_data[0], o_xlat[0]}), 32'b100101);
    repeat (2) @(posedge sclk);
    #1;
    rst_n = 1'b1;
    repeat (20) begin @(posedge sclk); #1; end

    // Fast timing: SENS toggles one cycle before capture, receiver decodes the select nibble
    in_sens[1] = 1'b0;
    send(1, {16'h0, CXD_SEL_BLIND_BRK, 4'h9}, 5'd8, 1'b0, t);
    at_cycle(t + 21);
    in_sens[1] = 1'b1;
    at_cycle(t + 23);
    check("t6_sync_latency", 1, 32'({o_sv[1], o_sval[1]}), 32'b10);
    wait_idle(1, 1'b0);
    check("t6_nibble", 1, 32'(last_nib[1]), 32'(CXD_SEL_BLIND_BRK));
    send(1, {16'h0, CXD_SEL_CLV, 4'h1}, 5'd8, 1'b0, t);
    wait_idle(1, 1'b0);
    repeat (3) begin @(posedge sclk); #1; end
    check("t6_value_hold", 1, 32'(o_sval[1]), 32'd1);
    check("t6_nibble2", 1, 32'(last_nib[1]), 32'(CXD_SEL_CLV));

    // Randomized frames on both instances
    for (int i = 0; i < 24; i++) begin
      int u;
      u = $urandom_range(0, 1);
      send(u, MB'($urandom), 5'($urandom_range(0, 31)), 1'b0, t);
      wait_idle(u, 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge sclk); #1; end
    end
    repeat (4) begin @(posedge sclk); #1; end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
